// File: rtl/slc3_pkg.sv
// Shared types and helpers for the SLC-3 core: opcode/state encodings,
// sign-extension helpers and the NZP reset value.
package slc3_pkg;

  typedef enum logic [3:0] {
    OP_BR    = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_AND   = 4'b0101,
    OP_LDR   = 4'b0110,
    OP_STR   = 4'b0111,
    OP_NOT   = 4'b1001,
    OP_JMP   = 4'b1100,
    OP_PAUSE = 4'b1101
  } opcode_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_FETCH_MEM,
    S_LOAD_IR,
    S_DECODE,
    S_EXEC,
    S_LD_ADDR,
    S_LD_MEM,
    S_LD_WB,
    S_ST_ADDR,
    S_ST_MEM,
    S_PAUSE_HI,
    S_PAUSE_LO
  } state_e;

  localparam logic [2:0] RESET_NZP = 3'b010;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])
      return 3'b100;
    else if (v == 16'h0000)
      return 3'b010;
    return 3'b001;
  endfunction

endpackage

// File: rtl/slc3_regfile.sv
// SLC-3 general register file: 8 x 16, two combinational read ports,
// one write port on the rising edge, asynchronous clear.
module slc3_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  ra_addr_i,
  output logic [15:0] ra_data_o,
  input  logic [2:0]  rb_addr_i,
  output logic [15:0] rb_data_o,
  input  logic        we_i,
  input  logic [2:0]  waddr_i,
  input  logic [15:0] wdata_i
);

  logic [15:0] rf_q [8];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = rf_q[ra_addr_i];
  assign rb_data_o = rf_q[rb_addr_i];

endmodule

// File: rtl/slc3_core.sv
// Multi-cycle SLC-3 core with a request/ready memory port.
// Optional PAUSE instruction (opcode 1101) enabled by defining SLC3_PAUSE_EN.
module slc3_core
  import slc3_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic              Continue,
  output logic [15:0]       pc_out,
  output logic [15:0]       ir_out,
  output logic [11:0]       led_out
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [2:0]  nzp_q, nzp_d;

  opcode_e     op;
  logic        is_alu;
  logic        br_taken;
  logic        mem_done;
  logic        rf_we;
  logic [2:0]  rb_addr;
  logic [15:0] ra_data, rb_data;
  logic [15:0] sr2, alu_res, eff_addr, rf_wdata;

  assign op       = opcode_e'(ir_q[15:12]);
  assign is_alu   = (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  assign br_taken = |(ir_q[11:9] & nzp_q);
  // STR reads its source through port B; ALU ops read SR2 there
  assign rb_addr  = (op == OP_STR) ? ir_q[11:9] : ir_q[2:0];

  slc3_regfile u_rf (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .ra_addr_i (ir_q[8:6]),
    .ra_data_o (ra_data),
    .rb_addr_i (rb_addr),
    .rb_data_o (rb_data),
    .we_i      (rf_we),
    .waddr_i   (ir_q[11:9]),
    .wdata_i   (rf_wdata)
  );

  assign sr2      = ir_q[5] ? sext5(ir_q[4:0]) : rb_data;
  assign eff_addr = ra_data + sext6(ir_q[5:0]);
  assign rf_wdata = (state_q == S_LD_WB) ? mdr_q : alu_res;

  always_comb begin
    alu_res = ra_data;
    case (op)
      OP_ADD:  alu_res = ra_data + sr2;
      OP_AND:  alu_res = ra_data & sr2;
      OP_NOT:  alu_res = ~ra_data;
      default: alu_res = ra_data;
    endcase
  end

  // ---- FSM: state register ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = S_FETCH_MEM;
      S_FETCH_MEM: if (mem_done) state_d = S_LOAD_IR;
      S_LOAD_IR:   state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP: state_d = S_EXEC;
          OP_LDR:   state_d = S_LD_ADDR;
          OP_STR:   state_d = S_ST_ADDR;
`ifdef SLC3_PAUSE_EN
          OP_PAUSE: state_d = S_PAUSE_HI;
`endif
          default:  state_d = S_FETCH;
        endcase
      end
      S_EXEC:      state_d = S_FETCH;
      S_LD_ADDR:   state_d = S_LD_MEM;
      S_LD_MEM:    if (mem_done) state_d = S_LD_WB;
      S_LD_WB:     state_d = S_FETCH;
      S_ST_ADDR:   state_d = S_ST_MEM;
      S_ST_MEM:    if (mem_done) state_d = S_FETCH;
`ifdef SLC3_PAUSE_EN
      S_PAUSE_HI:  if (Continue) state_d = S_PAUSE_LO;
      S_PAUSE_LO:  if (!Continue) state_d = S_FETCH;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  // ---- FSM: outputs (Moore, so an async reset drops mem_req at once) ----
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      S_FETCH_MEM, S_LD_MEM: mem_req = 1'b1;
      S_ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_EXEC:  rf_we = is_alu;
      S_LD_WB: rf_we = 1'b1;
      default: ;
    endcase
  end

  assign mem_done = mem_req && mem_ready;

  // ---- datapath next-state ----
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    nzp_d = nzp_q;
    case (state_q)
      S_FETCH: begin
        mar_d = pc_q;
        pc_d  = pc_q + 16'd1;
      end
      S_FETCH_MEM, S_LD_MEM: if (mem_done) mdr_d = mem_rdata;
      S_LOAD_IR: ir_d = mdr_q;
      S_EXEC: begin
        if (is_alu)
          nzp_d = nzp_of(alu_res);
        else if (op == OP_BR && br_taken)
          pc_d = pc_q + sext9(ir_q[8:0]);
        else if (op == OP_JMP)
          pc_d = ra_data;
      end
      S_LD_ADDR: mar_d = eff_addr;
      S_LD_WB:   nzp_d = nzp_of(mdr_q);
      S_ST_ADDR: begin
        mar_d = eff_addr;
        mdr_d = rb_data;
      end
      default: ;
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      nzp_q <= RESET_NZP;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      nzp_q <= nzp_d;
    end
  end

`ifdef SLC3_PAUSE_EN
  logic [11:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (state_q == S_DECODE && op == OP_PAUSE) led_d = ir_q[11:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) led_q <= '0;
    else       led_q <= led_d;
  end

  assign led_out = led_q;
`else
  logic unused_continue;
  assign unused_continue = Continue;
  assign led_out         = '0;
`endif

  assign mem_addr  = mar_q[ADDR_W-1:0];
  assign mem_wdata = mdr_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;

endmodule
